// File: rtl/mont_pkg.sv
// ============================================================================
// Module   : mont_pkg
// Purpose  : Shared widths, state and operation encodings for mont_exp_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mont_pkg;

   localparam int MONT_W  = 192;
   localparam int MONT_EW = 192;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SCAN    = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_RELEASE = 3'd4,
      ST_NEXT    = 3'd5,
      ST_FIN     = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      OP_SQR      = 2'd0,
      OP_MUL      = 2'd1,
      OP_CONV_IN  = 2'd2,
      OP_CONV_OUT = 2'd3
   } op_e;

   function automatic int cnt_width(input int ew);
      return (ew > 1) ? $clog2(ew) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mont_exp_ctrl_if.sv
// ============================================================================
// Module   : mont_exp_req_if / mont_mm_if
// Purpose  : Exponentiation request bus and Montgomery multiplier bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mont_exp_req_if #(
   parameter int W  = mont_pkg::MONT_W,
   parameter int EW = mont_pkg::MONT_EW
);
   logic          start;
   logic [W-1:0]  base;
   logic [EW-1:0] exp;
   logic [W-1:0]  one_m;
   logic [W-1:0]  r2;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;

   modport master (output start, base, exp, one_m, r2, input busy, done, result);
   modport slave  (input start, base, exp, one_m, r2, output busy, done, result);
endinterface

interface mont_mm_if #(
   parameter int W = mont_pkg::MONT_W
);
   logic [W-1:0] mm_x;
   logic [W-1:0] mm_y;
   logic         mm_start;
   logic [W-1:0] mm_z;
   logic         mm_done;

   modport master (output mm_x, mm_y, mm_start, input mm_z, mm_done);
   modport slave  (input mm_x, mm_y, mm_start, output mm_z, mm_done);
endinterface

`default_nettype wire

// File: rtl/mont_exp_bitscan.sv
// ============================================================================
// Module   : mont_exp_bitscan
// Purpose  : Exponent shift register (MSB = current bit) and remaining-bit count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mont_exp_bitscan
   import mont_pkg::*;
#(
   parameter int EW = MONT_EW,
   parameter int CW = cnt_width(EW)
) (
   input  wire logic          clk_i,
   input  wire logic          rst_i,
   input  wire logic          load_i,
   input  wire logic [EW-1:0] exp_i,
   input  wire logic          shift_i,
   input  wire logic          dec_i,
   output logic               bit_o,
   output logic               empty_o
);

   logic [EW-1:0] exp_q, exp_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Counter tracks bits below the current MSB; shifting out the leading one
   // is a shift without a decrement.
   always_comb begin
      exp_d = exp_q;
      cnt_d = cnt_q;
      if (load_i) begin
         exp_d = exp_i;
         cnt_d = CW'(EW - 1);
      end else begin
         if (shift_i) exp_d = {exp_q[EW-2:0], 1'b0};
         if (dec_i)   cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         exp_q <= '0;
         cnt_q <= '0;
      end else begin
         exp_q <= exp_d;
         cnt_q <= cnt_d;
      end
   end

   assign bit_o   = exp_q[EW-1];
   assign empty_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mont_exp_ctrl.sv
// ============================================================================
// Module   : mont_exp_ctrl
// Purpose  : Left-to-right square-and-multiply sequencer driving a Montgomery
//            multiplier. Optional in/out domain conversion: MONT_EXP_CONVERT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mont_exp_ctrl
   import mont_pkg::*;
#(
   parameter int W  = MONT_W,
   parameter int EW = MONT_EW
) (
   input  wire logic       clk,
   input  wire logic       reset,
   mont_exp_req_if.slave   req,
   mont_mm_if.master       mm
);

   state_e        state_q;
   op_e           op_q;
   logic          sqr_done_q;
   logic [W-1:0]  base_q;
   logic [W-1:0]  acc_q;
   logic          busy_q;
   logic          done_q;
   logic [W-1:0]  result_q;
   logic [W-1:0]  mm_x_q;
   logic [W-1:0]  mm_y_q;
   logic          mm_start_q;

   logic          w_load;
   logic          w_shift;
   logic          w_dec;
   logic          w_bit;
   logic          w_empty;

`ifdef MONT_EXP_CONVERT_EN
   logic [W-1:0]  r2_q;
`else
   logic          w_unused_r2;
   assign w_unused_r2 = ^req.r2;
`endif

   mont_exp_bitscan #(.EW(EW)) u_bitscan (
      .clk_i   (clk),
      .rst_i   (reset),
      .load_i  (w_load),
      .exp_i   (req.exp),
      .shift_i (w_shift),
      .dec_i   (w_dec),
      .bit_o   (w_bit),
      .empty_o (w_empty)
   );

   always_comb begin
      w_load  = (state_q == ST_IDLE) && req.start;
      w_shift = 1'b0;
      w_dec   = 1'b0;
      case (state_q)
         ST_SCAN: begin
            w_shift = 1'b1;
            w_dec   = !w_bit;
         end
         ST_NEXT: begin
            // The bit under examination is consumed once its square is done.
            w_shift = sqr_done_q;
            w_dec   = sqr_done_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_SQR;
         sqr_done_q <= 1'b0;
         base_q     <= '0;
         acc_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         mm_x_q     <= '0;
         mm_y_q     <= '0;
         mm_start_q <= 1'b0;
`ifdef MONT_EXP_CONVERT_EN
         r2_q       <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req.start) begin
                  base_q     <= req.base;
                  acc_q      <= req.one_m;
                  busy_q     <= 1'b1;
                  sqr_done_q <= 1'b0;
`ifdef MONT_EXP_CONVERT_EN
                  r2_q       <= req.r2;
                  if (req.exp == '0) begin
                     acc_q   <= W'(1);
                     state_q <= ST_FIN;
                  end else begin
                     op_q    <= OP_CONV_IN;
                     state_q <= ST_ISSUE;
                  end
`else
                  state_q    <= (req.exp == '0) ? ST_FIN : ST_SCAN;
`endif
               end
            end
            ST_SCAN: begin
               if (w_bit) begin
                  acc_q   <= base_q;
                  state_q <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               if (!sqr_done_q) begin
                  if (w_empty) begin
`ifdef MONT_EXP_CONVERT_EN
                     op_q    <= OP_CONV_OUT;
                     state_q <= ST_ISSUE;
`else
                     state_q <= ST_FIN;
`endif
                  end else begin
                     op_q       <= OP_SQR;
                     sqr_done_q <= 1'b1;
                     state_q    <= ST_ISSUE;
                  end
               end else begin
                  sqr_done_q <= 1'b0;
                  if (w_bit) begin
                     op_q    <= OP_MUL;
                     state_q <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               case (op_q)
                  OP_MUL: begin
                     mm_x_q <= acc_q;
                     mm_y_q <= base_q;
                  end
`ifdef MONT_EXP_CONVERT_EN
                  OP_CONV_IN: begin
                     mm_x_q <= base_q;
                     mm_y_q <= r2_q;
                  end
                  OP_CONV_OUT: begin
                     mm_x_q <= acc_q;
                     mm_y_q <= W'(1);
                  end
`endif
                  default: begin
                     mm_x_q <= acc_q;
                     mm_y_q <= acc_q;
                  end
               endcase
               mm_start_q <= 1'b1;
               state_q    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mm.mm_done) begin
                  if (op_q == OP_CONV_IN) base_q <= mm.mm_z;
                  else                    acc_q  <= mm.mm_z;
                  mm_start_q <= 1'b0;
                  state_q    <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (!mm.mm_done) begin
`ifdef MONT_EXP_CONVERT_EN
                  case (op_q)
                     OP_CONV_IN:  state_q <= ST_SCAN;
                     OP_CONV_OUT: state_q <= ST_FIN;
                     default:     state_q <= ST_NEXT;
                  endcase
`else
                  state_q <= ST_NEXT;
`endif
               end
            end
            ST_FIN: begin
               result_q <= acc_q;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req.busy    = busy_q;
   assign req.done    = done_q;
   assign req.result  = result_q;
   assign mm.mm_x     = mm_x_q;
   assign mm.mm_y     = mm_y_q;
   assign mm.mm_start = mm_start_q;

endmodule

`default_nettype wire

// File: tb/tb_mont_exp_ctrl.sv
// ============================================================================
// Module   : tb_mont_exp_ctrl
// Purpose  : Directed vectors for mont_exp_ctrl against a mod-13 multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mont_exp_ctrl;
   import mont_pkg::*;

   localparam int W  = MONT_W;
   localparam int EW = MONT_EW;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mont_exp_req_if req_if ();
   mont_mm_if      mm_if ();

   mont_exp_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .req   (req_if),
      .mm    (mm_if)
   );

   int errors = 0;
   int checks = 0;
   int issues = 0;
   int rsp_lat = 3;
   int rsp_hold = 0;
   int rsp_phase = 0;
   int rsp_cnt = 0;
   logic [W-1:0] rsp_x, rsp_y;

   typedef struct {
      logic [W-1:0]  base;
      logic [EW-1:0] e;
      logic [W-1:0]  one_m;
      int            lat;
      int            hold;
      int            poke;
      logic [W-1:0]  res;
      int            mults;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   function automatic logic [W-1:0] mulmod13(input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned am, bm;
      am = int'(a % 13);
      bm = int'(b % 13);
      return W'((am * bm) % 13);
   endfunction

   // Multiplier model: product after rsp_lat cycles, done held until start drops
   // and then rsp_hold further cycles.
   initial begin
      mm_if.mm_done = 1'b0;
      mm_if.mm_z    = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            rsp_phase     = 0;
            mm_if.mm_done = 1'b0;
         end else begin
            case (rsp_phase)
               0: if (mm_if.mm_start) begin
                     rsp_x = mm_if.mm_x;
                     rsp_y = mm_if.mm_y;
                     rsp_cnt = rsp_lat;
                     issues++;
                     rsp_phase = 1;
                  end
               1: if (!mm_if.mm_start) rsp_phase = 0;
                  else begin
                     rsp_cnt--;
                     if (rsp_cnt <= 0) begin
                        mm_if.mm_z    = mulmod13(rsp_x, rsp_y);
                        mm_if.mm_done = 1'b1;
                        rsp_phase     = 2;
                     end
                  end
               2: if (!mm_if.mm_start) begin
                     if (rsp_hold == 0) begin
                        mm_if.mm_done = 1'b0;
                        rsp_phase     = 0;
                     end else begin
                        rsp_cnt   = rsp_hold;
                        rsp_phase = 3;
                     end
                  end
               default: begin
                  rsp_cnt--;
                  if (rsp_cnt <= 0) begin
                     mm_if.mm_done = 1'b0;
                     rsp_phase     = 0;
                  end
               end
            endcase
         end
      end
   end

   task automatic run_exp(input vec_t v, output logic [W-1:0] res, output logic [W-1:0] res_late,
                          output int dones, output int extra, output bit timed_out);
      rsp_lat  = v.lat;
      rsp_hold = v.hold;
      issues   = 0;
      @(negedge clk);
      req_if.base  = v.base;
      req_if.exp   = v.e;
      req_if.one_m = v.one_m;
      req_if.r2    = W'(1);
      req_if.start = 1'b1;
      @(negedge clk);
      req_if.start = 1'b0;
      dones = 0;
      timed_out = 1'b1;
      for (int c = 0; c < 30000; c++) begin
         if (req_if.done) begin
            dones++;
            timed_out = 1'b0;
            break;
         end
         if (v.poke != 0 && c == v.poke) begin
            req_if.start = 1'b1;
            req_if.base  = W'(3);
            req_if.exp   = EW'(4);
         end else begin
            req_if.start = 1'b0;
         end
         @(negedge clk);
      end
      req_if.start = 1'b0;
      res = req_if.result;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (req_if.done) extra++;
      end
      res_late = req_if.result;
   endtask

   initial begin
      logic [EW-1:0] big;
      logic [W-1:0]  res, res_late, want_res;
      int            dones, extra, want_mults;
      bit            tmo;
      vec_t          v;

      big = '0;
      big[EW-1] = 1'b1;
      //          base    exp        one_m  lat hold poke  result mults
      vecs[0] = '{W'(2), EW'(5),   W'(1), 3,  0,   0,   W'(6), 3};
      vecs[1] = '{W'(3), EW'(4),   W'(1), 5,  0,   0,   W'(3), 2};
      vecs[2] = '{W'(2), EW'(0),   W'(1), 3,  0,   0,   W'(1), 0};
      vecs[3] = '{W'(5), EW'(13),  W'(1), 20, 0,   0,   W'(5), 5};
      vecs[4] = '{W'(7), EW'(255), W'(1), 7,  0,   0,   W'(5), 14};
      vecs[5] = '{W'(2), big,      W'(1), 3,  0,   0,   W'(9), 191};
      vecs[6] = '{W'(2), EW'(5),   W'(1), 4,  10,  6,   W'(6), 3};
      vecs[7] = '{W'(4), EW'(0),   W'(7), 3,  0,   0,   W'(7), 0};
      vecs[8] = '{W'(6), EW'(1),   W'(1), 3,  0,   0,   W'(6), 0};

      reset = 1'b1;
      req_if.start = 1'b0;
      req_if.base  = '0;
      req_if.exp   = '0;
      req_if.one_m = '0;
      req_if.r2    = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_busy",     W'(req_if.busy),     W'(0));
      check("reset_done",     W'(req_if.done),     W'(0));
      check("reset_mm_start", W'(mm_if.mm_start),  W'(0));
      check("reset_result",   req_if.result,       W'(0));
      check("reset_mm_x",     mm_if.mm_x,          W'(0));
      check("reset_mm_y",     mm_if.mm_y,          W'(0));

      // exp == 0 latency: busy one edge after start, done on the following edge.
      issues = 0;
      req_if.base  = W'(5);
      req_if.exp   = '0;
      req_if.one_m = W'(1);
      req_if.r2    = W'(1);
      req_if.start = 1'b1;
      @(posedge clk); #1;
      req_if.start = 1'b0;
      check("exp0_busy_e0", W'(req_if.busy), W'(1));
      check("exp0_done_e0", W'(req_if.done), W'(0));
      @(posedge clk); #1;
      check("exp0_done_e1",   W'(req_if.done), W'(1));
      check("exp0_busy_e1",   W'(req_if.busy), W'(0));
      check("exp0_result",    req_if.result,   W'(1));
      @(posedge clk); #1;
      check("exp0_done_e2",   W'(req_if.done), W'(0));
      check("exp0_no_mm",     W'(issues),      W'(0));

      for (int i = 0; i < 9; i++) begin
         v = vecs[i];
         want_res   = v.res;
         want_mults = v.mults;
`ifdef MONT_EXP_CONVERT_EN
         if (v.e == '0) want_res = W'(1);
         else           want_mults = want_mults + 2;
`endif
         run_exp(v, res, res_late, dones, extra, tmo);
         check($sformatf("v%0d_timeout", i),    W'(tmo),        W'(0));
         check($sformatf("v%0d_result", i),     res,            want_res);
         check($sformatf("v%0d_result_hold", i), res_late,      want_res);
         check($sformatf("v%0d_mults", i),      W'(issues),     W'(want_mults));
         check($sformatf("v%0d_dones", i),      W'(dones + extra), W'(1));
         check($sformatf("v%0d_busy_after", i), W'(req_if.busy), W'(0));
      end

      // Asynchronous reset while a product is outstanding.
      rsp_lat  = 20;
      rsp_hold = 0;
      @(negedge clk);
      req_if.base  = W'(2);
      req_if.exp   = EW'(5);
      req_if.one_m = W'(1);
      req_if.start = 1'b1;
      @(negedge clk);
      req_if.start = 1'b0;
      tmo = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (mm_if.mm_start) begin
            tmo = 1'b0;
            break;
         end
         @(negedge clk);
      end
      check("rst_wait_reached", W'(tmo), W'(0));
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_async_mm_start", W'(mm_if.mm_start), W'(0));
      check("rst_async_busy",     W'(req_if.busy),    W'(0));
      @(negedge clk);
      reset = 1'b0;
      run_exp(vecs[0], res, res_late, dones, extra, tmo);
      want_mults = 3;
`ifdef MONT_EXP_CONVERT_EN
      want_mults = 5;
`endif
      check("rst_rerun_timeout", W'(tmo),    W'(0));
      check("rst_rerun_result",  res,        W'(6));
      check("rst_rerun_mults",   W'(issues), W'(want_mults));
      check("rst_rerun_dones",   W'(dones + extra), W'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
